// File: rtl/dht11_poll_sched_pkg.sv
// Shared state encoding, outcome codes and frame checksum helper for the DHT11 poll scheduler.
package dht11_poll_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAILX = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SENSOR  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CKSUM   = 2'd3;

    // DHT11 checksum: 8-bit wrapping sum of the four data bytes.
    function automatic logic frame_ok(input logic [7:0] hi, input logic [7:0] hf,
                                      input logic [7:0] ti, input logic [7:0] tf,
                                      input logic [7:0] ck);
        logic [7:0] sum;
        sum = hi + hf + ti + tf;
        return (sum == ck);
    endfunction

endpackage

// File: rtl/dht11_poll_sched_cksum.sv
// Combinational frame checksum compare; used only when DHT_CKSUM_CHECK_EN is defined.
module dht11_poll_sched_cksum
    import dht11_poll_sched_pkg::*;
(
    input  logic [7:0] hi,
    input  logic [7:0] hf,
    input  logic [7:0] ti,
    input  logic [7:0] tf,
    input  logic [7:0] ck,
    output logic       ok
);

    assign ok = frame_ok(hi, hf, ti, tf, ck);

endmodule

// File: rtl/dht11_poll_sched.sv
// DHT11 reader supervisor: arms the core, enforces the re-read gap, retries, latches good frames.
// Optional checksum validation is enabled by defining DHT_CKSUM_CHECK_EN.
module dht11_poll_sched
    import dht11_poll_sched_pkg::*;
#(
    parameter int MIN_GAP_CYC  = 100_000_000,
    parameter int TIMEOUT_CYC  = 3_000_000,
    parameter int AUTO_PER_CYC = 250_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       auto,
    output logic       sens_en,
    output logic       sens_rst,
    input  logic       sens_wait,
    input  logic       sens_err,
    input  logic [7:0] sens_hi,
    input  logic [7:0] sens_hf,
    input  logic [7:0] sens_ti,
    input  logic [7:0] sens_tf,
    input  logic [7:0] sens_ck,
    output logic [7:0] hum_i,
    output logic [7:0] hum_f,
    output logic [7:0] tmp_i,
    output logic [7:0] tmp_f,
    output logic       valid,
    output logic       done,
    output logic       fail,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [31:0] GAP_LOAD  = 32'(MIN_GAP_CYC);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PER_CYC - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t      state_r;
    logic [31:0] gap_r;
    logic [31:0] timer_r;
    logic [31:0] auto_cnt_r;
    logic [7:0]  retry_r;
    logic [1:0]  code_r;
    logic        seen_r;
    logic        pend_r;
    logic        sens_en_r;
    logic        sens_rst_r;
    logic [31:0] data_r;
    logic        valid_r;
    logic        done_r;
    logic        fail_r;
    logic [1:0]  err_code_r;
    logic        auto_fire_s;
    logic        new_req_s;
    logic        ck_ok_s;

`ifdef DHT_CKSUM_CHECK_EN
    dht11_poll_sched_cksum u_cksum (
        .hi (sens_hi),
        .hf (sens_hf),
        .ti (sens_ti),
        .tf (sens_tf),
        .ck (sens_ck),
        .ok (ck_ok_s)
    );
`else
    logic unused_ck_s;
    assign unused_ck_s = ^sens_ck;
    assign ck_ok_s     = 1'b1;
`endif

    assign auto_fire_s = auto && (auto_cnt_r == AUTO_LAST);
    assign new_req_s   = req || auto_fire_s;

    // Free-running auto-request period counter, parked at zero while auto is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_r <= 32'd0;
        end else if (!auto || auto_fire_s) begin
            auto_cnt_r <= 32'd0;
        end else begin
            auto_cnt_r <= auto_cnt_r + 32'd1;
        end
    end

    // Request bookkeeping, gap enforcement and transfer supervision FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gap_r      <= GAP_LOAD;
            timer_r    <= 32'd0;
            retry_r    <= 8'd0;
            code_r     <= ERR_NONE;
            seen_r     <= 1'b0;
            pend_r     <= 1'b0;
            sens_en_r  <= 1'b1;
            sens_rst_r <= 1'b0;
            data_r     <= 32'd0;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            sens_en_r <= 1'b1;
            done_r    <= 1'b0;
            fail_r    <= 1'b0;
            if (new_req_s) begin
                pend_r <= 1'b1;
            end
            if (state_r != ST_RUN && gap_r != 32'd0) begin
                gap_r <= gap_r - 32'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    sens_rst_r <= 1'b0;
                    if (pend_r && gap_r == 32'd0) begin
                        state_r    <= ST_RUN;
                        timer_r    <= 32'd0;
                        seen_r     <= 1'b0;
                        sens_rst_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    timer_r <= timer_r + 32'd1;
                    if (sens_wait) begin
                        seen_r <= 1'b1;
                    end
                    // Core error beats a completed frame, which beats the timeout.
                    if (sens_err) begin
                        code_r     <= ERR_SENSOR;
                        state_r    <= ST_FAILX;
                        sens_rst_r <= 1'b0;
                        gap_r      <= GAP_LOAD;
                    end else if (seen_r && !sens_wait) begin
                        state_r    <= ST_CHECK;
                        sens_rst_r <= 1'b0;
                        gap_r      <= GAP_LOAD;
                    end else if (timer_r == TO_LAST) begin
                        code_r     <= ERR_TIMEOUT;
                        state_r    <= ST_FAILX;
                        sens_rst_r <= 1'b0;
                        gap_r      <= GAP_LOAD;
                    end
                end
                ST_CHECK: begin
                    gap_r <= GAP_LOAD;
                    if (ck_ok_s) begin
                        data_r     <= {sens_hi, sens_hf, sens_ti, sens_tf};
                        valid_r    <= 1'b1;
                        done_r     <= 1'b1;
                        err_code_r <= ERR_NONE;
                        pend_r     <= new_req_s;
                        retry_r    <= 8'd0;
                        state_r    <= ST_IDLE;
                    end else begin
                        code_r  <= ERR_CKSUM;
                        state_r <= ST_FAILX;
                    end
                end
                ST_FAILX: begin
                    err_code_r <= code_r;
                    state_r    <= ST_IDLE;
                    if (retry_r < RETRY_MAX) begin
                        retry_r <= retry_r + 8'd1;
                    end else begin
                        fail_r  <= 1'b1;
                        pend_r  <= new_req_s;
                        retry_r <= 8'd0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sens_rst_r <= 1'b0;
                end
            endcase
        end
    end

    assign sens_en  = sens_en_r;
    assign sens_rst = sens_rst_r;
    assign hum_i    = data_r[31:24];
    assign hum_f    = data_r[23:16];
    assign tmp_i    = data_r[15:8];
    assign tmp_f    = data_r[7:0];
    assign valid    = valid_r;
    assign done     = done_r;
    assign fail     = fail_r;
    assign err_code = err_code_r;
    assign busy     = pend_r;

endmodule
